led_div_seq: RTL

LED_DIV_SEQ -- requirements
Module: led_div_seq

---
 rtl/led_div_seq.sv | 74 +++++++
 1 files changed

// File: rtl/led_div_seq.sv
// led_div_seq: sweeps an LED divisor between MIN and MAX on a prescaled tick, with wrap/bounce modes and a manual override.
module led_div_seq #(
  parameter int TICK_DIV = 100000
) (
  input  logic        clk100,
  input  logic        rst,
  input  logic        cfg_we_i,
  input  logic [2:0]  cfg_addr_i,
  input  logic [15:0] cfg_data_i,
  output logic [11:0] div_o,
  output logic        wren_o,
  output logic        busy_o,
  output logic        dir_o
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  state_t state, state_n;
  logic en, mode;
  logic [11:0] mn, mx, div_n, up_div, dn_div;
  logic [15:0] per, per_m1, cnt, cnt_n;
  logic [PW-1:0] pre, pre_n;
  logic run, tick, done, step, manual, load, oor, at_max, at_min, up_dir, dn_dir, dir_n, wren_n;
  always_ff @(posedge clk100 or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb state_n = !en ? IDLE : state == IDLE ? LOAD : RUN;
  always_comb begin
    run    = state == RUN && en;
    tick   = run && pre == PMAX;
    per_m1 = per == 16'd0 ? 16'd0 : per - 16'd1;
    done   = tick && cnt >= per_m1;
    step   = done && mn < mx;
    manual = state == IDLE && cfg_we_i && cfg_addr_i == 3'd4;
    load   = state == LOAD && en;
    oor    = div_o < mn || div_o > mx;
    at_max = div_o == mx;
    at_min = div_o == mn;
    pre_n  = run && !tick ? pre + 1'b1 : '0;
    cnt_n  = !run || done ? 16'd0 : tick ? cnt + 16'd1 : cnt;
    up_div = !at_max ? div_o + 12'd1 : mode ? mx - 12'd1 : mn;
    up_dir = !(at_max && mode);
    dn_div = at_min ? mn + 12'd1 : div_o - 12'd1;
    dn_dir = at_min;
    div_n  = manual ? cfg_data_i[11:0] : load ? mn : !step ? div_o : oor ? mn : dir_o ? up_div : dn_div;
    dir_n  = load ? 1'b1 : !step ? dir_o : oor ? 1'b1 : dir_o ? up_dir : dn_dir;
    wren_n = manual || load || step;
  end
  always_ff @(posedge clk100 or posedge rst)
    if (rst) begin
      div_o  <= '0;
      wren_o <= 1'b0;
      dir_o  <= 1'b1;
      busy_o <= 1'b0;
      pre    <= '0;
      cnt    <= '0;
      en     <= 1'b0;
      mode   <= 1'b0;
      mn     <= 12'd1;
      mx     <= 12'd4095;
      per    <= 16'd1;
    end else begin
      div_o  <= div_n;
      wren_o <= wren_n;
      dir_o  <= dir_n;
      busy_o <= state_n != IDLE;
      pre    <= pre_n;
      cnt    <= cnt_n;
      if (cfg_we_i && cfg_addr_i == 3'd0) {mode, en} <= cfg_data_i[1:0];
      if (cfg_we_i && cfg_addr_i == 3'd1) mn <= cfg_data_i[11:0];
      if (cfg_we_i && cfg_addr_i == 3'd2) mx <= cfg_data_i[11:0];
      if (cfg_we_i && cfg_addr_i == 3'd3) per <= cfg_data_i;
    end
endmodule
